// File: rtl/input_metadata_insert_pkg.sv
// input_metadata_insert_pkg: shared constants, FSM state type and metadata builder
package input_metadata_insert_pkg;

    localparam logic [7:0] GMII_PREAMBLE = 8'h55;
    localparam logic [7:0] GMII_SFD      = 8'hD5;
    localparam int         META_BYTES    = 8;
    localparam int         FRAME_DELAY   = 9;
    localparam int         META_PORT_LSB = 60;
    localparam int         META_RSVD_LSB = 48;
    localparam int         META_TIME_LSB = 0;

    typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DISCARD} state_t;

    function automatic logic [63:0] build_meta(input logic [3:0] port, input logic [47:0] ts);
        logic [63:0] m;
        m = '0;
        m[META_PORT_LSB +: 4]  = port;
        m[META_RSVD_LSB +: 12] = 12'h0;
        m[META_TIME_LSB +: 48] = ts;
        return m;
    endfunction

endpackage

// File: rtl/input_metadata_insert_byte_delay_line.sv
// byte_delay_line: fixed-depth shift register of {valid, byte}, shifting every cycle
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_byte   : stage 0 input
//   out_valid, out_byte : last stage output
module byte_delay_line
    import input_metadata_insert_pkg::*;
#(
    parameter int DEPTH = FRAME_DELAY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    output logic [7:0] out_byte
);

    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0][7:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            data  <= '0;
        end else begin
            valid <= {valid[DEPTH-2:0], in_valid};
            data  <= {data[DEPTH-2:0], in_byte};
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_byte  = data[DEPTH-1];

endmodule

// File: rtl/input_metadata_insert.sv
// input_metadata_insert: strips GMII preamble/SFD and prepends 8 bytes of port/timestamp metadata
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_gmii_rx_dv, iv_gmii_rxd : GMII receive valid and byte
//   iv_syned_global_time  : free-running global time, captured on SFD
//   ov_data, o_data_wr    : {first/last flag, byte} and its write strobe
//   ov_pkt_cnt, ov_err_cnt: forwarded / rejected frame counters
module input_metadata_insert
    import input_metadata_insert_pkg::*;
#(
    parameter logic [3:0] PORT_ID = 4'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_gmii_rx_dv,
    input  logic [7:0]  iv_gmii_rxd,
    input  logic [47:0] iv_syned_global_time,
    output logic [8:0]  ov_data,
    output logic        o_data_wr,
    output logic [15:0] ov_pkt_cnt,
    output logic [15:0] ov_err_cnt
);

    state_t      state, state_nxt;
    logic        sof;
    logic [3:0]  meta_cnt;
    logic [3:0]  last_cnt;
    logic [47:0] ts;
    logic        err_inc, ts_load, meta_load, last_load;
    logic        busy, pre_ok;
    logic        line_valid;
    logic [7:0]  line_byte;
    logic [63:0] meta;
    logic [2:0]  meta_sel;
    logic [7:0]  meta_byte;

    // last_cnt runs from the frame-end cycle until the last byte leaves the delay line,
    // which is exactly the tail of the busy window
    assign busy   = last_cnt != 4'd0;
    assign pre_ok = iv_gmii_rxd == GMII_PREAMBLE && !busy;

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        ts_load   = 1'b0;
        meta_load = 1'b0;
        last_load = 1'b0;
        case (state)
            IDLE: if (i_gmii_rx_dv) begin
                state_nxt = pre_ok ? PREAMBLE : DISCARD;
                err_inc   = !pre_ok;
            end
            PREAMBLE: if (!i_gmii_rx_dv) begin
                state_nxt = IDLE;
                err_inc   = 1'b1;
            end else if (iv_gmii_rxd == GMII_SFD) begin
                state_nxt = FRAME;
                ts_load   = 1'b1;
            end else if (iv_gmii_rxd != GMII_PREAMBLE) begin
                state_nxt = DISCARD;
                err_inc   = 1'b1;
            end
            FRAME: if (!i_gmii_rx_dv) begin
                state_nxt = IDLE;
                err_inc   = sof;
                last_load = !sof;
            end else begin
                meta_load = sof;
            end
            DISCARD: if (!i_gmii_rx_dv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            sof        <= 1'b0;
            ts         <= '0;
            meta_cnt   <= '0;
            last_cnt   <= '0;
            ov_pkt_cnt <= '0;
            ov_err_cnt <= '0;
        end else begin
            state      <= state_nxt;
            sof        <= ts_load;
            ts         <= ts_load ? iv_syned_global_time : ts;
            meta_cnt   <= meta_load ? 4'(META_BYTES) : meta_cnt != 4'd0 ? meta_cnt - 4'd1 : 4'd0;
            last_cnt   <= last_load ? 4'(META_BYTES) : last_cnt != 4'd0 ? last_cnt - 4'd1 : 4'd0;
            ov_pkt_cnt <= ov_pkt_cnt + {15'd0, last_cnt == 4'd1};
            ov_err_cnt <= ov_err_cnt + {15'd0, err_inc};
        end
    end

    byte_delay_line #(.DEPTH(FRAME_DELAY)) u_line (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .in_valid  (state == FRAME && i_gmii_rx_dv),
        .in_byte   (iv_gmii_rxd),
        .out_valid (line_valid),
        .out_byte  (line_byte)
    );

    // meta_cnt counts 8..1 across metadata bytes 0..7; its low bits minus one select MSB-first
    assign meta      = build_meta(PORT_ID, ts);
    assign meta_sel  = meta_cnt[2:0] - 3'd1;
    assign meta_byte = meta[{meta_sel, 3'b000} +: 8];

    assign o_data_wr = meta_cnt != 4'd0 || line_valid;
    assign ov_data   = meta_cnt != 4'd0 ? {meta_cnt == 4'd8, meta_byte} :
                       line_valid       ? {last_cnt == 4'd1, line_byte} : 9'h0;

endmodule

// File: tb/tb_input_metadata_insert.sv
// tb_input_metadata_insert: directed self-checking bench for input_metadata_insert
module tb_input_metadata_insert;

    typedef logic [8:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [47:0] gtime = 48'h0;
    logic [8:0]  data;
    logic        wr;
    logic [15:0] pkt, err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int s_cyc = 0;
    logic [8:0] words[$];
    int wcyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wr) begin
        words.push_back(data);
        wcyc.push_back(cyc);
    end

    input_metadata_insert #(.PORT_ID(4'd3)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_gmii_rx_dv         (dv),
        .iv_gmii_rxd          (rxd),
        .iv_syned_global_time (gtime),
        .ov_data              (data),
        .o_data_wr            (wr),
        .ov_pkt_cnt           (pkt),
        .ov_err_cnt           (err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [7:0] b);
        @(posedge clk);
        #1;
        dv  = v;
        rxd = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    // timestamp differs before SFD, during SFD, and after, so only the SFD-cycle value is valid
    task automatic send_frame(input int npre, input int n, input logic [7:0] b0, input logic [47:0] t);
        gtime = 48'hFFFF_0000_FFFF;
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        gtime = t;
        for (int k = 0; k < n; k++) begin
            drive(1'b1, b0 + 8'(k));
            if (k == 0) begin
                gtime = ~t;
                s_cyc = cyc;
            end
        end
        drive(1'b0, 8'h00);
    endtask

    function automatic wq_t build_exp(input int n, input logic [7:0] b0, input logic [47:0] t);
        wq_t q;
        logic [63:0] m;
        m = {4'd3, 12'h0, t};
        for (int i = 0; i < 8; i++) q.push_back({i == 0, m[63-8*i -: 8]});
        for (int k = 0; k < n; k++) q.push_back({k == n - 1, b0 + 8'(k)});
        return q;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        tests++; if (wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b exp 0", wr); end
        tests++; if (data !== 9'h0) begin fails++; $display("FAIL reset_data: got %h exp 000", data); end
        tests++; if (pkt !== 16'h0) begin fails++; $display("FAIL reset_pkt: got %0d exp 0", pkt); end
        tests++; if (err !== 16'h0) begin fails++; $display("FAIL reset_err: got %0d exp 0", err); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_long_frame();
        wq_t e;
        words.delete();
        wcyc.delete();
        send_frame(7, 64, 8'h00, 48'h0000_1234_5678);
        idle(15);
        e = build_exp(64, 8'h00, 48'h0000_1234_5678);
        tests++; if (words.size() != 72) begin fails++; $display("FAIL long_count: got %0d exp 72", words.size()); end
        for (int i = 0; i < 72 && i < words.size(); i++) begin
            tests++; if (words[i] !== e[i]) begin fails++; $display("FAIL long_word[%0d]: got %h exp %h", i, words[i], e[i]); end
        end
        if (words.size() > 0) begin
            tests++; if (wcyc[0] != s_cyc + 1) begin fails++; $display("FAIL long_latency: got cycle %0d exp %0d", wcyc[0], s_cyc + 1); end
            tests++; if (wcyc[wcyc.size()-1] - wcyc[0] != wcyc.size() - 1) begin fails++; $display("FAIL long_contiguous: span %0d exp %0d", wcyc[wcyc.size()-1] - wcyc[0], wcyc.size() - 1); end
        end
        tests++; if (pkt !== 16'd1) begin fails++; $display("FAIL long_pkt: got %0d exp 1", pkt); end
        tests++; if (err !== 16'd0) begin fails++; $display("FAIL long_err: got %0d exp 0", err); end
    endtask

    task automatic test_single_byte();
        wq_t e;
        words.delete();
        send_frame(1, 1, 8'hAA, 48'hA1B2_C3D4_E5F6);
        idle(12);
        e = build_exp(1, 8'hAA, 48'hA1B2_C3D4_E5F6);
        tests++; if (words.size() != 9) begin fails++; $display("FAIL single_count: got %0d exp 9", words.size()); end
        for (int i = 0; i < 9 && i < words.size(); i++) begin
            tests++; if (words[i] !== e[i]) begin fails++; $display("FAIL single_word[%0d]: got %h exp %h", i, words[i], e[i]); end
        end
        tests++; if (pkt !== 16'd2) begin fails++; $display("FAIL single_pkt: got %0d exp 2", pkt); end
    endtask

    task automatic test_zero_len();
        words.delete();
        send_frame(2, 0, 8'h00, 48'h1);
        idle(12);
        tests++; if (words.size() != 0) begin fails++; $display("FAIL zero_count: got %0d exp 0", words.size()); end
        tests++; if (err !== 16'd1) begin fails++; $display("FAIL zero_err: got %0d exp 1", err); end
        tests++; if (pkt !== 16'd2) begin fails++; $display("FAIL zero_pkt: got %0d exp 2", pkt); end
    endtask

    task automatic test_discard();
        wq_t e;
        logic [7:0] bad [8];
        bad = '{8'h55, 8'h12, 8'h37, 8'hD5, 8'h55, 8'h01, 8'h02, 8'h03};
        words.delete();
        for (int i = 0; i < 8; i++) drive(1'b1, bad[i]);
        idle(12);
        tests++; if (words.size() != 0) begin fails++; $display("FAIL discard_count: got %0d exp 0", words.size()); end
        tests++; if (err !== 16'd2) begin fails++; $display("FAIL discard_err: got %0d exp 2", err); end
        send_frame(3, 4, 8'hC0, 48'h0102_0304_0506);
        idle(12);
        e = build_exp(4, 8'hC0, 48'h0102_0304_0506);
        tests++; if (words.size() != 12) begin fails++; $display("FAIL discard_good_count: got %0d exp 12", words.size()); end
        for (int i = 0; i < 12 && i < words.size(); i++) begin
            tests++; if (words[i] !== e[i]) begin fails++; $display("FAIL discard_good_word[%0d]: got %h exp %h", i, words[i], e[i]); end
        end
        tests++; if (pkt !== 16'd3) begin fails++; $display("FAIL discard_pkt: got %0d exp 3", pkt); end
    endtask

    task automatic test_back_to_back();
        wq_t e;
        words.delete();
        send_frame(7, 20, 8'h40, 48'h0000_AAAA_BBBB);
        idle(3);
        send_frame(2, 10, 8'h80, 48'h0000_CCCC_DDDD);
        idle(20);
        e = build_exp(20, 8'h40, 48'h0000_AAAA_BBBB);
        tests++; if (words.size() != 28) begin fails++; $display("FAIL b2b_count: got %0d exp 28", words.size()); end
        for (int i = 0; i < 28 && i < words.size(); i++) begin
            tests++; if (words[i] !== e[i]) begin fails++; $display("FAIL b2b_word[%0d]: got %h exp %h", i, words[i], e[i]); end
        end
        tests++; if (err !== 16'd3) begin fails++; $display("FAIL b2b_err: got %0d exp 3", err); end
        tests++; if (pkt !== 16'd4) begin fails++; $display("FAIL b2b_pkt: got %0d exp 4", pkt); end
    endtask

    task automatic test_reset_mid();
        wq_t e;
        logic [47:0] t;
        t = 48'h1122_3344_5566;
        words.delete();
        gtime = 48'h0;
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        gtime = t;
        for (int k = 0; k <= 6; k++) drive(1'b1, 8'(k));
        #1;
        tests++; if (wr !== 1'b1 || data !== {1'b0, t[23:16]}) begin fails++; $display("FAIL mid_meta5: got wr=%b data=%h exp wr=1 data=%h", wr, data, {1'b0, t[23:16]}); end
        #1 rst_n = 1'b0;
        #1;
        words.delete();
        tests++; if (wr !== 1'b0) begin fails++; $display("FAIL mid_rst_wr: got %b exp 0", wr); end
        tests++; if (data !== 9'h0) begin fails++; $display("FAIL mid_rst_data: got %h exp 000", data); end
        tests++; if (pkt !== 16'd0 || err !== 16'd0) begin fails++; $display("FAIL mid_rst_cnt: got pkt=%0d err=%0d exp 0 0", pkt, err); end
        drive(1'b1, 8'h07);
        rst_n = 1'b1;
        drive(1'b1, 8'h08);
        drive(1'b1, 8'h09);
        idle(12);
        tests++; if (words.size() != 0) begin fails++; $display("FAIL mid_tail_count: got %0d exp 0", words.size()); end
        tests++; if (err !== 16'd1) begin fails++; $display("FAIL mid_tail_err: got %0d exp 1", err); end
        send_frame(4, 6, 8'h20, 48'h0000_0000_BEEF);
        idle(12);
        e = build_exp(6, 8'h20, 48'h0000_0000_BEEF);
        tests++; if (words.size() != 14) begin fails++; $display("FAIL mid_clean_count: got %0d exp 14", words.size()); end
        for (int i = 0; i < 14 && i < words.size(); i++) begin
            tests++; if (words[i] !== e[i]) begin fails++; $display("FAIL mid_clean_word[%0d]: got %h exp %h", i, words[i], e[i]); end
        end
        tests++; if (pkt !== 16'd1) begin fails++; $display("FAIL mid_clean_pkt: got %0d exp 1", pkt); end
        tests++; if (err !== 16'd1) begin fails++; $display("FAIL mid_clean_err: got %0d exp 1", err); end
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_single_byte();
        test_zero_len();
        test_discard();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
